uart_ctrl: RTL and testbench
============================

Name: uart_ctrl

Overview:
- Peripheral-side responder for the CPU's UART port group (uart_wdata, uart_write_ce, uart_rdata, clean_recv_flag, recv_flag, send_flag).
- Serialises CPU-written bytes onto txd as 8N1 frames and deserialises 8N1 frames from rxd into a one-byte holding register.
- Handshakes with the mem stage through send_flag (transmitter ready) and recv_flag / clean_recv_flag (byte available / consumed).
- Sits in the SoC wrapper beside the ROM/SRAM controllers; drives the board UART pins.

Parameters:
- CLKS_PER_BIT, default 5208: clk cycles per bit (50 MHz / 9600 baud); must be ≥ 4.
- SYNC_STAGES, default 2: rxd synchroniser flop count.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- uart_wdata  in  8  byte to transmit.
- uart_write_ce  in  1  transmit request; sampled each cycle.
- send_flag  out  1  1 = transmitter idle, request accepted.
- uart_rdata  out  8  last received byte.
- recv_flag  out  1  1 = unread byte in uart_rdata.
- clean_recv_flag  in  1  CPU consumed byte; clears recv_flag.
- rx_overrun  out  1  sticky: byte overwritten while recv_flag = 1.
- txd  out  1  serial out, idle high.
- rxd  in  1  serial in, asynchronous.

Behaviour:
- Reset values: txd = 1, send_flag = 1, recv_flag = 0, rx_overrun = 0, uart_rdata = 8'h00. Both FSMs go to IDLE and all counters clear.
- Reset mid-frame aborts the frame. txd = 1 from the next cycle; no partial byte is latched.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: at a rising edge where uart_write_ce = 1 and send_flag = 1, latch uart_wdata, go to START, txd <= 0, send_flag <= 0.
  - Each state lasts exactly CLKS_PER_BIT cycles, counted by a bit-timer.
  - DATA: shift LSB first, 8 bits, with a 3-bit index.
  - STOP: txd = 1 for CLKS_PER_BIT cycles, then IDLE with send_flag <= 1.
- TX timing: a frame occupies 10*CLKS_PER_BIT cycles from the first txd-low cycle.
  - uart_write_ce while send_flag = 0 is ignored and the byte is dropped.
  - uart_write_ce held high retriggers on the first cycle send_flag is 1 again; the mem stage must pulse it.
- RX input: rxd passes through SYNC_STAGES flops. All RX logic uses the synchronised value rxs.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: rxs = 0 goes to START with the timer cleared.
  - START: at count CLKS_PER_BIT/2 (integer divide), sample rxs. If 1, treat as a glitch and return to IDLE. If 0, go to DATA and restart the timer.
  - DATA: sample at each full CLKS_PER_BIT (mid-bit); shift in LSB first; 8 samples.
  - STOP: sample at mid-bit.
    - rxs = 1: uart_rdata <= shift register, recv_flag <= 1, then IDLE.
    - rxs = 0 (framing error): discard the byte, leave flags unchanged, then wait in STOP until rxs = 1 before IDLE.
- recv_flag / overrun rules:
  - clean_recv_flag = 1 sets recv_flag <= 0 and rx_overrun <= 0.
  - Byte completes while recv_flag = 1 and clean_recv_flag = 0: uart_rdata overwritten, recv_flag stays 1, rx_overrun <= 1.
  - Byte completes on the same cycle as clean_recv_flag: clear is applied first, then set. Result: recv_flag = 1, new data, rx_overrun = 0.
- TX and RX are fully independent; full duplex.
- Timers: width clog2(CLKS_PER_BIT); wrap to 0 on reaching CLKS_PER_BIT-1.

Decomposition:
- Package uart_pkg:
  - TX/RX state enum (2-bit: IDLE, START, DATA, STOP).
  - Constants for 8 data bits, 1 stop bit, line idle level 1'b1.
  - A function computing timer width from CLKS_PER_BIT.
- One sub-module, uart_rx_core: synchroniser, RX FSM, shift register. Outputs a one-cycle byte_valid pulse plus the byte.
- uart_ctrl keeps the TX FSM and the recv_flag / overrun / uart_rdata registers.

Test Plan (all with CLKS_PER_BIT = 8):
- TX frame: pulse uart_write_ce with uart_wdata = 8'hA5 after reset.
  - send_flag = 0 next cycle.
  - txd sequence, 8 cycles per bit: 0,1,0,1,0,0,1,0,1,1.
  - send_flag = 1 exactly 80 cycles after the first txd-low cycle.
- TX busy: second write of 8'h3C issued 20 cycles into the 8'hA5 frame → ignored. The frame is unchanged and no further frame follows.
- RX byte: drive rxd with an 8N1 frame of 8'h5A.
  - recv_flag rises after the stop-bit mid-sample; uart_rdata = 8'h5A.
  - clean_recv_flag pulse → recv_flag = 0 next cycle.
- RX glitch and framing error:
  - 3-cycle low pulse on rxd → no byte, RX FSM returns to IDLE.
  - Frame of 8'hFF with stop bit = 0 → recv_flag stays 0, uart_rdata unchanged.
- Overrun and simultaneous clear:
  - Receive 8'h11 then 8'h22 without a clear → uart_rdata = 8'h22, rx_overrun = 1.
  - Repeat with clean_recv_flag asserted on the byte-complete cycle → recv_flag = 1, rx_overrun = 0.
- Reset mid-operation: assert rst at cycle 30 of a TX frame and mid-RX.
  - Next cycle: txd = 1, send_flag = 1, recv_flag = 0.
  - A subsequent 8'h0F write transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART controller. Defines
//               the 2-bit TX/RX state encoding and the frame-format constants
//               for 8N1. Also provides the helper that sizes the bit timers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    // Shared by the TX and RX state machines
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned c_DATA_BITS = 8;
    localparam int unsigned c_STOP_BITS = 1;
    localparam logic        c_LINE_IDLE = 1'b1;
    localparam logic [2:0]  c_LAST_BIT  = 3'(c_DATA_BITS - 1);

    // Bit-timer width: the timer counts 0 .. cpb-1
    function automatic int unsigned timer_width(input int unsigned cpb);
        return (cpb < 2) ? 1 : $clog2(cpb);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_core.sv
// ============================================================================
// Module      : uart_rx_core
// Description : 8N1 receiver. Synchronises rxd, detects the start bit, and
//               confirms it at half a bit time. Samples each data bit at its
//               middle, LSB first, then checks the stop bit. A good stop bit
//               produces a one-cycle byte_valid_o pulse. On that cycle,
//               byte_o already holds the assembled byte.
// Ports       : clk          - system clock
//               rst          - synchronous active-high reset
//               rxd_i        - asynchronous serial input
//               byte_valid_o - one-cycle pulse, byte received correctly
//               byte_o       - received byte (valid with byte_valid_o)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o
);

    localparam int unsigned      c_TW       = timer_width(CLKS_PER_BIT);
    localparam logic [c_TW-1:0]  c_CNT_MAX  = c_TW'(CLKS_PER_BIT - 1);
    localparam logic [c_TW-1:0]  c_CNT_HALF = c_TW'(CLKS_PER_BIT / 2);

    logic [SYNC_STAGES-1:0] r_sync_q;
    logic                   w_rxs;

    uart_state_e     r_state_q, w_state_d;
    logic [c_TW-1:0] r_cnt_q,   w_cnt_d;
    logic [2:0]      r_bit_q,   w_bit_d;
    logic [7:0]      r_shift_q, w_shift_d;
    logic            r_ferr_q,  w_ferr_d;

    // The synchroniser resets to the idle level, so a reset never looks like a start bit
    generate
        if (SYNC_STAGES == 1) begin : g_sync_single
            always_ff @(posedge clk) begin
                if (rst) r_sync_q <= {SYNC_STAGES{c_LINE_IDLE}};
                else     r_sync_q <= rxd_i;
            end
        end else begin : g_sync_chain
            always_ff @(posedge clk) begin
                if (rst) r_sync_q <= {SYNC_STAGES{c_LINE_IDLE}};
                else     r_sync_q <= {r_sync_q[SYNC_STAGES-2:0], rxd_i};
            end
        end
    endgenerate

    assign w_rxs  = r_sync_q[SYNC_STAGES-1];
    assign byte_o = r_shift_q;

    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_d      = r_cnt_q;
        w_bit_d      = r_bit_q;
        w_shift_d    = r_shift_q;
        w_ferr_d     = r_ferr_q;
        byte_valid_o = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (!w_rxs) begin
                    w_state_d = ST_START;
                    w_cnt_d   = '0;
                end
            end
            ST_START: begin
                // Recheck at half a bit time. A line that is high again was a glitch.
                if (r_cnt_q == c_CNT_HALF) begin
                    w_cnt_d   = '0;
                    w_bit_d   = '0;
                    w_state_d = w_rxs ? ST_IDLE : ST_DATA;
                end else begin
                    w_cnt_d = r_cnt_q + c_TW'(1);
                end
            end
            ST_DATA: begin
                // The timer now wraps at mid-bit, because it restarted at the middle of the start bit
                if (r_cnt_q == c_CNT_MAX) begin
                    w_cnt_d   = '0;
                    w_shift_d = {w_rxs, r_shift_q[7:1]};
                    if (r_bit_q == c_LAST_BIT) w_state_d = ST_STOP;
                    else                       w_bit_d   = r_bit_q + 3'd1;
                end else begin
                    w_cnt_d = r_cnt_q + c_TW'(1);
                end
            end
            ST_STOP: begin
                if (r_ferr_q) begin
                    // Framing error: hold off until the line returns to idle
                    if (w_rxs) begin
                        w_ferr_d  = 1'b0;
                        w_state_d = ST_IDLE;
                    end
                end else if (r_cnt_q == c_CNT_MAX) begin
                    w_cnt_d = '0;
                    if (w_rxs) begin
                        byte_valid_o = 1'b1;
                        w_state_d    = ST_IDLE;
                    end else begin
                        w_ferr_d = 1'b1;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + c_TW'(1);
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_cnt_q   <= '0;
            r_bit_q   <= '0;
            r_shift_q <= '0;
            r_ferr_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_bit_q   <= w_bit_d;
            r_shift_q <= w_shift_d;
            r_ferr_q  <= w_ferr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_ctrl.sv
// ============================================================================
// Module      : uart_ctrl
// Description : Full-duplex 8N1 UART responder for the CPU port group.
//               The TX state machine serialises accepted bytes onto txd.
//               uart_rx_core deserialises rxd. This module holds the
//               receive byte, the byte-available flag and the sticky
//               overrun flag.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               uart_wdata      - byte to transmit
//               uart_write_ce   - transmit request (accepted when send_flag=1)
//               send_flag       - transmitter idle
//               uart_rdata      - last received byte
//               recv_flag       - unread byte in uart_rdata
//               clean_recv_flag - CPU consumed the byte
//               rx_overrun      - sticky, unread byte was overwritten
//               txd / rxd       - serial output / asynchronous serial input
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208,  // must be >= 4
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] uart_wdata,
    input  logic       uart_write_ce,
    output logic       send_flag,
    output logic [7:0] uart_rdata,
    output logic       recv_flag,
    input  logic       clean_recv_flag,
    output logic       rx_overrun,
    output logic       txd,
    input  logic       rxd
);

    localparam int unsigned     c_TW      = timer_width(CLKS_PER_BIT);
    localparam logic [c_TW-1:0] c_CNT_MAX = c_TW'(CLKS_PER_BIT - 1);

    uart_state_e     r_tx_state_q, w_tx_state_d;
    logic [c_TW-1:0] r_tx_cnt_q,   w_tx_cnt_d;
    logic [2:0]      r_tx_bit_q,   w_tx_bit_d;
    logic [7:0]      r_tx_shift_q, w_tx_shift_d;
    logic            r_txd_q,      w_txd_d;
    logic            r_send_q,     w_send_d;

    logic [7:0]      r_rdata_q,    w_rdata_d;
    logic            r_recv_q,     w_recv_d;
    logic            r_ovr_q,      w_ovr_d;

    logic            w_rx_valid;
    logic [7:0]      w_rx_byte;

    assign txd        = r_txd_q;
    assign send_flag  = r_send_q;
    assign uart_rdata = r_rdata_q;
    assign recv_flag  = r_recv_q;
    assign rx_overrun = r_ovr_q;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SYNC_STAGES  (SYNC_STAGES)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .rxd_i        (rxd),
        .byte_valid_o (w_rx_valid),
        .byte_o       (w_rx_byte)
    );

    // TX: txd is registered, so every bit holds for exactly CLKS_PER_BIT cycles
    always_comb begin
        w_tx_state_d = r_tx_state_q;
        w_tx_cnt_d   = r_tx_cnt_q;
        w_tx_bit_d   = r_tx_bit_q;
        w_tx_shift_d = r_tx_shift_q;
        w_txd_d      = r_txd_q;
        w_send_d     = r_send_q;

        case (r_tx_state_q)
            ST_IDLE: begin
                if (uart_write_ce && r_send_q) begin
                    w_tx_shift_d = uart_wdata;
                    w_tx_state_d = ST_START;
                    w_tx_cnt_d   = '0;
                    w_txd_d      = 1'b0;
                    w_send_d     = 1'b0;
                end
            end
            ST_START: begin
                if (r_tx_cnt_q == c_CNT_MAX) begin
                    w_tx_cnt_d   = '0;
                    w_tx_bit_d   = '0;
                    w_tx_state_d = ST_DATA;
                    w_txd_d      = r_tx_shift_q[0];
                end else begin
                    w_tx_cnt_d = r_tx_cnt_q + c_TW'(1);
                end
            end
            ST_DATA: begin
                if (r_tx_cnt_q == c_CNT_MAX) begin
                    w_tx_cnt_d = '0;
                    if (r_tx_bit_q == c_LAST_BIT) begin
                        w_tx_state_d = ST_STOP;
                        w_txd_d      = c_LINE_IDLE;
                    end else begin
                        w_tx_bit_d   = r_tx_bit_q + 3'd1;
                        w_tx_shift_d = {1'b0, r_tx_shift_q[7:1]};
                        w_txd_d      = r_tx_shift_q[1];
                    end
                end else begin
                    w_tx_cnt_d = r_tx_cnt_q + c_TW'(1);
                end
            end
            ST_STOP: begin
                if (r_tx_cnt_q == c_CNT_MAX) begin
                    w_tx_cnt_d   = '0;
                    w_tx_state_d = ST_IDLE;
                    w_send_d     = 1'b1;
                end else begin
                    w_tx_cnt_d = r_tx_cnt_q + c_TW'(1);
                end
            end
            default: begin
                w_tx_state_d = ST_IDLE;
                w_txd_d      = c_LINE_IDLE;
                w_send_d     = 1'b1;
            end
        endcase
    end

    // Receive holding register. The CPU clear is applied before a completing
    // byte, so a byte that lands on the clear cycle is kept and does not
    // count as an overrun.
    always_comb begin
        w_rdata_d = r_rdata_q;
        w_recv_d  = r_recv_q;
        w_ovr_d   = r_ovr_q;

        if (clean_recv_flag) begin
            w_recv_d = 1'b0;
            w_ovr_d  = 1'b0;
        end
        if (w_rx_valid) begin
            if (w_recv_d) w_ovr_d = 1'b1;
            w_recv_d  = 1'b1;
            w_rdata_d = w_rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state_q <= ST_IDLE;
            r_tx_cnt_q   <= '0;
            r_tx_bit_q   <= '0;
            r_tx_shift_q <= '0;
            r_txd_q      <= c_LINE_IDLE;
            r_send_q     <= 1'b1;
            r_rdata_q    <= 8'h00;
            r_recv_q     <= 1'b0;
            r_ovr_q      <= 1'b0;
        end else begin
            r_tx_state_q <= w_tx_state_d;
            r_tx_cnt_q   <= w_tx_cnt_d;
            r_tx_bit_q   <= w_tx_bit_d;
            r_tx_shift_q <= w_tx_shift_d;
            r_txd_q      <= w_txd_d;
            r_send_q     <= w_send_d;
            r_rdata_q    <= w_rdata_d;
            r_recv_q     <= w_recv_d;
            r_ovr_q      <= w_ovr_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_ctrl.sv
// ============================================================================
// Module      : tb_uart_ctrl
// Description : Self-checking bench for uart_ctrl with CLKS_PER_BIT = 8.
//               A frame-level model predicts txd, send_flag, recv_flag,
//               rx_overrun and uart_rdata on every cycle. Directed scenarios
//               and randomised full-duplex traffic are checked against it.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_ctrl;

    localparam int CPB  = 8;
    localparam int SYNC = 2;
    // Edges from the first rxd-low edge until the stop-bit decision:
    // synchroniser delay, half-bit start confirmation (+1 for the entry cycle),
    // then 8 data bits and the stop bit at one bit time each.
    localparam int LAT  = SYNC + CPB/2 + 1 + 9*CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] uart_wdata = 8'h00;
    logic       uart_write_ce = 1'b0;
    logic       clean_recv_flag = 1'b0;
    logic       rxd = 1'b1;
    logic       send_flag, recv_flag, rx_overrun, txd;
    logic [7:0] uart_rdata;

    always #5 clk = ~clk;

    uart_ctrl #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
        .clk             (clk),
        .rst             (rst),
        .uart_wdata      (uart_wdata),
        .uart_write_ce   (uart_write_ce),
        .send_flag       (send_flag),
        .uart_rdata      (uart_rdata),
        .recv_flag       (recv_flag),
        .clean_recv_flag (clean_recv_flag),
        .rx_overrun      (rx_overrun),
        .txd             (txd),
        .rxd             (rxd)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int at; logic [7:0] d; } rx_ev_t;
    rx_ev_t     rxq[$];
    int         m_tx_rem = 0;      // cycles left in the current TX frame
    logic [9:0] m_tx_frame = '1;   // stop, data[7:0], start (bit 0 sent first)
    logic       m_recv = 1'b0, m_ovr = 1'b0, m_ok = 1'b0;
    logic [7:0] m_rdata = 8'h00;

    function automatic logic m_exp_txd();
        if (m_tx_rem == 0) return 1'b1;
        return m_tx_frame[(10*CPB - m_tx_rem) / CPB];
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_tx_rem = 0;
            m_recv   = 1'b0;
            m_ovr    = 1'b0;
            m_rdata  = 8'h00;
            rxq.delete();
            m_ok     = 1'b1;
        end else begin
            if (m_tx_rem > 0) m_tx_rem--;
            else if (uart_write_ce) begin
                m_tx_frame = {1'b1, uart_wdata, 1'b0};
                m_tx_rem   = 10*CPB;
            end
            if (clean_recv_flag) begin
                m_recv = 1'b0;
                m_ovr  = 1'b0;
            end
            if (rxq.size() > 0 && rxq[0].at == cyc) begin
                if (m_recv) m_ovr = 1'b1;
                m_recv  = 1'b1;
                m_rdata = rxq[0].d;
                void'(rxq.pop_front());
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (m_ok) begin
            chk("txd",        txd,        m_exp_txd());
            chk("send_flag",  send_flag,  (m_tx_rem == 0));
            chk("recv_flag",  recv_flag,  m_recv);
            chk("rx_overrun", rx_overrun, m_ovr);
            chk("uart_rdata", uart_rdata, m_rdata);
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_write(input logic [7:0] d, input int hold);
        uart_wdata    = d;
        uart_write_ce = 1'b1;
        tick(hold);
        uart_write_ce = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop, input logic clr_at_done);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        if (stop) rxq.push_back(rx_ev_t'{at: cyc + 1 + LAT, d: d});
        for (int b = 0; b < 9; b++) begin
            rxd = f[b];
            tick(CPB);
        end
        rxd = f[9];
        tick(CPB - 1);
        if (clr_at_done) clean_recv_flag = 1'b1;
        tick(1);
        clean_recv_flag = 1'b0;
        rxd = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [9:0] a5_exp;
        a5_exp = 10'b1101001010;

        tick(3);
        rst = 1'b0;
        chk("reset txd",        txd,        1);
        chk("reset send_flag",  send_flag,  1);
        chk("reset recv_flag",  recv_flag,  0);
        chk("reset rx_overrun", rx_overrun, 0);
        chk("reset uart_rdata", uart_rdata, 8'h00);
        tick(2);

        // TX frame of A5 with an ignored write of 3C 20 cycles in
        uart_wdata    = 8'hA5;
        uart_write_ce = 1'b1;
        tick(1);
        uart_write_ce = 1'b0;
        for (int k = 0; k <= 100; k++) begin
            if (k == 0)  chk("a5 send_flag low", send_flag, 0);
            if (k == 19) begin uart_wdata = 8'h3C; uart_write_ce = 1'b1; end
            if (k == 20) uart_write_ce = 1'b0;
            if (k % 8 == 4 && k < 80) begin
                chk("a5 txd bit",       txd,         a5_exp[k/8]);
                chk("a5 model txd bit", m_exp_txd(), a5_exp[k/8]);
            end
            if (k == 79) chk("a5 send_flag at 79", send_flag, 0);
            if (k == 80) chk("a5 send_flag at 80", send_flag, 1);
            if (k == 100) begin
                chk("a5 no second frame txd", txd, 1);
                chk("a5 no second frame send", send_flag, 1);
            end
            tick(1);
        end

        // RX byte 5A then CPU clear
        rx_frame(8'h5A, 1'b1, 1'b0);
        chk("rx 5a recv_flag",  recv_flag,  1);
        chk("rx 5a uart_rdata", uart_rdata, 8'h5A);
        chk("rx 5a overrun",    rx_overrun, 0);
        clean_recv_flag = 1'b1;
        tick(1);
        clean_recv_flag = 1'b0;
        chk("clear recv_flag", recv_flag, 0);

        // Glitch, then framing error
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(20);
        chk("glitch recv_flag",  recv_flag,  0);
        chk("glitch uart_rdata", uart_rdata, 8'h5A);
        rx_frame(8'hFF, 1'b0, 1'b0);
        tick(10);
        chk("framing recv_flag",  recv_flag,  0);
        chk("framing uart_rdata", uart_rdata, 8'h5A);

        // Overrun, then byte completing on the clear cycle
        rx_frame(8'h11, 1'b1, 1'b0);
        tick(5);
        rx_frame(8'h22, 1'b1, 1'b0);
        chk("overrun uart_rdata", uart_rdata, 8'h22);
        chk("overrun flag",       rx_overrun, 1);
        chk("overrun recv_flag",  recv_flag,  1);
        tick(5);
        rx_frame(8'h44, 1'b1, 1'b1);
        chk("simul clear recv_flag",  recv_flag,  1);
        chk("simul clear overrun",    rx_overrun, 0);
        chk("simul clear uart_rdata", uart_rdata, 8'h44);

        // Reset 30 cycles into a TX frame while an RX frame is in progress
        tick(5);
        uart_wdata    = 8'hC3;
        uart_write_ce = 1'b1;
        rxd           = 1'b0;
        tick(1);
        uart_write_ce = 1'b0;
        tick(29);
        rst = 1'b1;
        rxd = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrst txd",        txd,        1);
        chk("midrst send_flag",  send_flag,  1);
        chk("midrst recv_flag",  recv_flag,  0);
        chk("midrst uart_rdata", uart_rdata, 8'h00);
        tick(3);
        tx_write(8'h0F, 1);
        tick(10*CPB + 5);
        chk("post-reset tx done", send_flag, 1);

        // Randomised full-duplex traffic
        fork
            begin
                for (int i = 0; i < 25; i++) begin
                    tick($urandom_range(0, 40));
                    tx_write(8'($urandom), ($urandom_range(0, 4) == 0) ? 90 : $urandom_range(1, 3));
                end
            end
            begin
                for (int i = 0; i < 25; i++) begin
                    int gap;
                    gap = $urandom_range(4, 24);
                    for (int g = 0; g < gap; g++) begin
                        clean_recv_flag = ($urandom_range(0, 5) == 0);
                        tick(1);
                    end
                    clean_recv_flag = 1'b0;
                    rx_frame(8'($urandom), ($urandom_range(0, 5) != 0), ($urandom_range(0, 3) == 0));
                end
            end
        join

        tick(100);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        bad++;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
